// File: rtl/fir_filter_par.sv
// Parallel-interface FIR filter: one MAC per cycle over a circular delay line,
// then round, shift and saturate the accumulator into a single output pulse.
module fir_filter_par #(
    parameter int DATA_W = 18,
    parameter int COEF_W = 18,
    parameter int TAPS   = 64,
    parameter int ACC_W  = 48,
    parameter int SHIFT  = 16,
    localparam int AW    = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     busy
);

    localparam int PW = DATA_W + COEF_W;
    localparam int SW = ACC_W + 1;

    localparam logic [SW-1:0] ONE_X = {{(SW-1){1'b0}}, 1'b1} << SHIFT;
    localparam logic signed [SW-1:0] RND = ONE_X >> 1;
    localparam logic signed [SW-1:0] OMAX =
        {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] OMIN =
        {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t                    state_q, state_d;
    logic [AW-1:0]             w_idx_q, w_idx_d;
    logic [AW-1:0]             k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [DATA_W-1:0]  out_sample_q, out_sample_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0]  delay_q [TAPS];
    logic signed [DATA_W-1:0]  delay_d [TAPS];
    logic signed [COEF_W-1:0]  coef_q [TAPS];
    logic signed [COEF_W-1:0]  coef_d [TAPS];

    logic [AW-1:0]             tap_idx;
    logic signed [PW-1:0]      prod;
    logic signed [SW-1:0]      rsum;
    logic signed [SW-1:0]      rshift;

    always_comb begin
        state_d      = state_q;
        w_idx_d      = w_idx_q;
        k_d          = k_q;
        acc_d        = acc_q;
        out_sample_d = out_sample_q;
        out_valid_d  = 1'b0;
        delay_d      = delay_q;
        coef_d       = coef_q;

        // Tap k reads the k-th most recent sample; AW-bit math wraps mod TAPS
        tap_idx = w_idx_q - AW'(1) - k_q;
        prod    = coef_q[k_q] * delay_q[tap_idx];
        rsum    = $signed({acc_q[ACC_W-1], acc_q}) + RND;
        rshift  = rsum >>> SHIFT;

        unique case (state_q)
            S_IDLE: begin
                if (coef_we) begin
                    coef_d[coef_addr] = coef_data;
                end
                if (in_valid) begin
                    delay_d[w_idx_q] = in_sample;
                    w_idx_d          = w_idx_q + AW'(1);
                    acc_d            = '0;
                    k_d              = '0;
                    state_d          = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
                k_d   = k_q + AW'(1);
                if (k_q == AW'(TAPS-1)) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (rshift > OMAX) begin
                    out_sample_d = OMAX[DATA_W-1:0];
                end else if (rshift < OMIN) begin
                    out_sample_d = OMIN[DATA_W-1:0];
                end else begin
                    out_sample_d = rshift[DATA_W-1:0];
                end
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            w_idx_q      <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            w_idx_q      <= w_idx_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            delay_q      <= delay_d;
            coef_q       <= coef_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;

endmodule

// File: tb/tb_fir_filter_par.sv
// Bench for fir_filter_par: two 8-tap instances (SHIFT=0 and SHIFT=16)
// with a queue scoreboard and per-instance output monitors.
module tb_fir_filter_par;

    localparam int DW = 18;
    localparam int CW = 18;
    localparam int TP = 8;
    localparam int AW = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 sel;
    logic                 in_valid;
    logic signed [DW-1:0] in_sample;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;

    logic                 rdy_a, ov_a, busy_a;
    logic signed [DW-1:0] os_a;
    logic                 rdy_b, ov_b, busy_b;
    logic signed [DW-1:0] os_b;

    int errors;
    int checks;
    int q_a[$];
    int q_b[$];
    int ov_cnt_a;
    int ev_a;
    int ev_b;

    fir_filter_par #(
        .DATA_W(DW), .COEF_W(CW), .TAPS(TP), .ACC_W(48), .SHIFT(0)
    ) u_a (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid & ~sel),
        .in_ready(rdy_a),
        .in_sample(in_sample),
        .coef_we(coef_we & ~sel),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .out_valid(ov_a),
        .out_sample(os_a),
        .busy(busy_a)
    );

    fir_filter_par #(
        .DATA_W(DW), .COEF_W(CW), .TAPS(TP), .ACC_W(48), .SHIFT(16)
    ) u_b (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid & sel),
        .in_ready(rdy_b),
        .in_sample(in_sample),
        .coef_we(coef_we & sel),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .out_valid(ov_b),
        .out_sample(os_b),
        .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (ov_a) begin
            ov_cnt_a++;
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL out_a_unexpected: got %0d, required no output",
                         os_a);
            end else begin
                ev_a = q_a.pop_front();
                if (int'(os_a) != ev_a) begin
                    errors++;
                    $display("FAIL out_a: got %0d, required %0d", os_a, ev_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ov_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL out_b_unexpected: got %0d, required no output",
                         os_b);
            end else begin
                ev_b = q_b.pop_front();
                if (int'(os_b) != ev_b) begin
                    errors++;
                    $display("FAIL out_b: got %0d, required %0d", os_b, ev_b);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    task automatic wait_rdy(input logic s);
        int n;
        n = 0;
        while (!(s ? rdy_b : rdy_a) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("ready_timeout", 0, 1);
        end
    endtask

    task automatic write_coef(input logic s, input int a, input int d);
        wait_rdy(s);
        sel       = s;
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = CW'(d);
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic send(input logic s, input int x, input int e,
                        input bit push);
        if (push) begin
            if (s) q_b.push_back(e);
            else   q_a.push_back(e);
        end
        sel       = s;
        in_sample = DW'(x);
        in_valid  = 1'b1;
        wait_rdy(s);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", q_a.size() + q_b.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    int cnt0;

    initial begin
        errors    = 0;
        checks    = 0;
        ov_cnt_a  = 0;
        rst_n     = 1'b0;
        sel       = 1'b0;
        in_valid  = 1'b0;
        in_sample = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_ready_a", rdy_a, 1);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_ovalid_a", ov_a, 0);
        chk("rst_osample_a", os_a, 0);
        chk("rst_ready_b", rdy_b, 1);
        chk("rst_busy_b", busy_b, 0);

        // Impulse response with coef[k] = k+1
        for (int k = 0; k < TP; k++) write_coef(0, k, k + 1);
        send(0, 100, 100, 1);
        for (int k = 1; k < TP; k++) send(0, 0, 100 * (k + 1), 1);
        send(0, 0, 0, 1);
        drain();

        // Continuous in_valid: one acceptance per TAPS+2 cycles
        wait_rdy(0);
        repeat (3) q_a.push_back(0);
        sel       = 1'b0;
        in_sample = '0;
        in_valid  = 1'b1;
        for (int t = 0; t <= 20; t++) begin
            chk("hs_ready", rdy_a, int'(t % 10 == 0));
            chk("hs_ovalid", ov_a, int'(t != 0 && t % 10 == 0));
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();

        // Coefficient write attempted during MAC is dropped
        send(0, 10, 10, 1);
        chk("busy_during_mac", busy_a, 1);
        sel       = 1'b0;
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_data = 18'sd5;
        repeat (3) @(negedge clk);
        coef_we   = 1'b0;
        send(0, 0, 20, 1);
        send(0, 7, 37, 1);
        drain();

        // Saturation at both rails, with a non-saturated crossover
        for (int k = 0; k < TP; k++) write_coef(0, k, 1000);
        for (int i = 0; i < 9; i++) send(0, 131071, 131071, 1);
        send(0, -131072, 131071, 1);
        send(0, -131072, 131071, 1);
        send(0, -131072, 131071, 1);
        send(0, -131072, -4000, 1);
        for (int i = 0; i < 5; i++) send(0, -131072, -131072, 1);
        drain();

        // Round-half-up then arithmetic shift by 16
        write_coef(1, 0, 1);
        send(1, 32768, 1, 1);
        send(1, 32767, 0, 1);
        send(1, -32768, 0, 1);
        send(1, -32769, -1, 1);
        send(1, 131071, 2, 1);
        send(1, -131072, -2, 1);
        drain();

        // Reset at k = TAPS/2 aborts the sample and clears coefficients
        send(0, 50, 0, 0);
        repeat (TP / 2) @(negedge clk);
        chk("busy_before_abort", busy_a, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt0  = ov_cnt_a;
        repeat (20) @(negedge clk);
        chk("abort_no_output", ov_cnt_a - cnt0, 0);
        chk("abort_ready", rdy_a, 1);
        chk("abort_busy", busy_a, 0);
        chk("abort_osample", os_a, 0);
        send(0, 100, 0, 1);
        drain();
        write_coef(0, 0, 3);
        send(0, 5, 15, 1);
        drain();

        chk("queues_empty", q_a.size() + q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
